// File: rtl/y_run_reporter.sv
// Measures runs of consecutive high y samples and queues each completed run
// length in a small FIFO that a valid/ready consumer drains.
module y_run_reporter #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_y_in,
  output logic [LEN_W-1:0] o_run_len,
  output logic             o_run_valid,
  input  logic             i_run_ready,
  output logic             o_overflow,
  output logic [15:0]      o_total_high
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]     DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [LEN_W-1:0]   CNT_MAX = '1;
  localparam logic [15:0]        TOT_MAX = 16'hFFFF;

  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic [15:0]      r_total;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_write;

  assign w_push  = !i_y_in && (r_cnt != '0);
  assign w_pop   = (r_count != '0) && i_run_ready;
  assign w_full  = (r_count == DEPTH_C);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_write = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr] <= r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_total    <= '0;
    end else begin
      if (i_y_in) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        if (r_total != TOT_MAX) r_total <= r_total + 16'd1;
      end else begin
        r_cnt <= '0;
      end
      if (w_write) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_run_valid  = (r_count != '0);
  assign o_run_len    = o_run_valid ? r_mem[r_rptr] : '0;
  assign o_overflow   = r_overflow;
  assign o_total_high = r_total;

endmodule

// File: tb/tb_y_run_reporter.sv
// Self-checking bench for y_run_reporter: a fixed vector table followed by
// model-driven scenarios whose expected outputs flow through a scoreboard queue.
module tb_y_run_reporter;

  localparam int LEN_W = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic        valid;
    logic [7:0]  len;
    logic        ovf;
    logic [15:0] total;
  } exp_t;

  typedef struct {
    logic        y;
    logic        ready;
    logic        valid;
    logic [7:0]  len;
    logic        ovf;
    logic [15:0] total;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        yIn;
  logic        runReady;
  logic [7:0]  runLen;
  logic        runValid;
  logic        overflow;
  logic [15:0] totalHigh;

  int errors;
  int checks;

  exp_t sbQ[$];
  int   mdlFifo[$];
  int   mdlCnt;
  int   mdlTotal;
  logic mdlOvf;

  vec_t vecs[8];

  y_run_reporter #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_y_in       (yIn),
    .o_run_len    (runLen),
    .o_run_valid  (runValid),
    .i_run_ready  (runReady),
    .o_overflow   (overflow),
    .o_total_high (totalHigh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void modelReset();
    mdlFifo.delete();
    mdlCnt   = 0;
    mdlTotal = 0;
    mdlOvf   = 1'b0;
  endfunction

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic applyStimulus(input logic y, input logic ready);
    bit   doPop;
    bit   doPush;
    bit   isFull;
    exp_t e;
    yIn      = y;
    runReady = ready;
    doPop  = (mdlFifo.size() != 0) && ready;
    doPush = !y && (mdlCnt != 0);
    isFull = (mdlFifo.size() == DEPTH);
    if (doPop) void'(mdlFifo.pop_front());
    if (doPush) begin
      if (isFull && !doPop) mdlOvf = 1'b1;
      else mdlFifo.push_back(mdlCnt);
    end
    if (y) begin
      if (mdlCnt < 255) mdlCnt++;
      if (mdlTotal < 65535) mdlTotal++;
    end else begin
      mdlCnt = 0;
    end
    e.valid = (mdlFifo.size() != 0);
    e.len   = (mdlFifo.size() != 0) ? 8'(mdlFifo[0]) : 8'd0;
    e.ovf   = mdlOvf;
    e.total = 16'(mdlTotal);
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sbQ.pop_front();
      check("sb_valid", int'(runValid), int'(e.valid));
      check("sb_len",   int'(runLen),   int'(e.len));
      check("sb_ovf",   int'(overflow), int'(e.ovf));
      check("sb_total", int'(totalHigh), int'(e.total));
    end
  endtask

  task automatic cycle(input logic y, input logic ready);
    applyStimulus(y, ready);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doRun(input int len, input logic ready);
    for (int i = 0; i < len; i++) cycle(1'b1, ready);
    cycle(1'b0, ready);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic resetDut();
    rst = 1'b0;
    #1;
    check("rst_valid", int'(runValid), 0);
    check("rst_len",   int'(runLen),   0);
    check("rst_ovf",   int'(overflow), 0);
    check("rst_total", int'(totalHigh), 0);
    modelReset();
    yIn      = 1'b0;
    runReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    yIn      = 1'b0;
    runReady = 1'b0;
    modelReset();

    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd2};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd3};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 16'd3};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd4};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 16'd4};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 16'd4};

    #3;
    resetDut();

    // Basic report: 0,1,1,1,0,1,0 with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].y, vecs[i].ready);
      check($sformatf("vec%0d_valid", i), int'(runValid),  int'(vecs[i].valid));
      check($sformatf("vec%0d_len", i),   int'(runLen),    int'(vecs[i].len));
      check($sformatf("vec%0d_ovf", i),   int'(overflow),  int'(vecs[i].ovf));
      check($sformatf("vec%0d_total", i), int'(totalHigh), int'(vecs[i].total));
    end

    // Overflow: five runs into a four-entry FIFO with no consumer.
    resetDut();
    for (int r = 1; r <= 5; r++) doRun(r, 1'b0);
    check("ovf_set", int'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_len", int'(runLen), i + 1);
      cycle(1'b0, 1'b1);
    end
    check("ovf_empty_valid", int'(runValid), 0);
    check("ovf_empty_len",   int'(runLen),   0);
    check("ovf_sticky",      int'(overflow), 1);

    // Push into a full FIFO on the same edge as a pop.
    resetDut();
    for (int r = 1; r <= 4; r++) doRun(r, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check("full_pp_ovf", int'(overflow), 0);
    check("full_pp_len", int'(runLen),   2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    check("full_pp_last", int'(runLen), 7);
    cycle(1'b0, 1'b1);
    check("full_pp_empty", int'(runValid), 0);

    // Run-length saturation with a long high stretch.
    resetDut();
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("sat_len",   int'(runLen),    255);
    check("sat_total", int'(totalHigh), 300);

    // Reset mid-run with records queued; only the post-reset run survives.
    resetDut();
    doRun(1, 1'b0);
    doRun(1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    #2;
    resetDut();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("mid_rst_len",   int'(runLen),    2);
    check("mid_rst_total", int'(totalHigh), 2);
    cycle(1'b0, 1'b1);
    check("mid_rst_only", int'(runValid), 0);

    // Stall: head record must hold while runs keep arriving.
    resetDut();
    doRun(3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle((i % 3) != 2, 1'b0);
      check("stall_len",   int'(runLen),   3);
      check("stall_valid", int'(runValid), 1);
    end

    // Minimum pattern 1,0,1,0 with randomly stalling consumer.
    resetDut();
    for (int i = 0; i < 40; i++) cycle(i[0] == 1'b0, 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
